mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between exe_stage and the writeback stage. Latches es_to_ms_bus.
//  For loads and stores, waits for the data-SRAM response (data_ok). For loads, extracts and
//  extends the addressed byte/half/word. Emits the writeback bus plus a forwarding/stall view to decode.
// PARAMETERS
//  ES_TO_MS_BUS_WD  82  input bus: {addr[1:0],mem_we,ld_w,ld_b,ld_bu,ld_h,ld_hu,st_w,st_b,st_h,
//                       res_from_mem,gr_we,dest[4:0],alu_result[31:0],pc[31:0]} (msb..lsb)
//  MS_TO_WS_BUS_WD  70  output bus: {gr_we,dest[4:0],final_result[31:0],pc[31:0]}
// PORTS
//  clk              in   1    clock, all state on rising edge
//  resetn           in   1    asynchronous, active-low reset
//  ws_allowin       in   1    writeback can accept this cycle
//  ms_allowin       out  1    mem_stage can accept from exe this cycle
//  es_to_ms_valid   in   1    exe presents a valid instruction
//  es_to_ms_bus     in   82   exe payload (layout above)
//  data_sram_data_ok in  1    one-cycle response pulse for the oldest outstanding request
//  data_sram_rdata  in   32   read data, valid when data_ok=1
//  ms_to_ws_valid   out  1    valid toward writeback
//  ms_to_ws_bus     out  70   writeback payload
//  ms_fwd_we        out  1    ms_valid & gr_we
//  ms_fwd_dest      out  5    destination register
//  ms_fwd_data      out  32   final_result (meaningful only when ms_fwd_pending=0)
//  ms_fwd_pending   out  1    load in stage whose data has not yet returned; decode must stall
// BEHAVIOUR
//  - States: IDLE (empty), WAIT (mem op, awaiting data_ok), DONE (result ready, awaiting ws_allowin).
//  - need_rsp = mem_we | res_from_mem, taken from the incoming bus.
//  - Accept when es_to_ms_valid & ms_allowin: latch bus; go to WAIT if need_rsp, else DONE.
//  - In WAIT with data_ok=1:
//    - rdata passes to the output combinationally in the same cycle.
//    - If ws_allowin=0, rdata is captured into data_buf and the state becomes DONE.
//  - ms_ready_go = (DONE) | (WAIT & data_ok).
//  - ms_allowin = IDLE | (ms_ready_go & ws_allowin).
//  - ms_to_ws_valid = ms_ready_go.
//  - Leaving with no new entry -> IDLE. Leaving with a simultaneous new entry -> new WAIT/DONE
//    (back-to-back, no bubble).
//  - A data_ok pulse in IDLE or DONE is ignored and never corrupts data_buf.
//  - Load extraction (addr = latched addr[1:0], src = data_buf or live rdata):
//    - ld_w: src.
//    - ld_b / ld_bu: byte src[8*addr+7 -: 8], sign- / zero-extended.
//    - ld_h / ld_hu: half selected by addr[1] (addr[0] ignored), sign- / zero-extended.
//  - final_result = res_from_mem ? extracted : alu_result. Stores: gr_we=0, final_result=alu_result.
//  - ms_fwd_pending = WAIT & res_from_mem & ~data_ok.
//  - Reset (resetn=0, asynchronous):
//    - state=IDLE, all bus/data registers = 0.
//    - Outputs: ms_allowin=1, ms_to_ws_valid=0, ms_fwd_we=0, ms_fwd_pending=0, buses=0.
//    - Mid-WAIT reset drops the instruction; a later stray data_ok is ignored per the IDLE rule.
//  - Latency: non-mem op 1 cycle in stage. Mem op 1 cycle + data_ok delay. Holding in DONE is unbounded.
// TESTING
//  1. ALU op (gr_we=1, dest=5, alu_result=0x1234, pc=0x1c000000), ws_allowin=1
//     -> next cycle ms_to_ws_valid=1, bus={1,5,0x1234,0x1c000000}; ms_allowin stays 1.
//  2. ld_b, addr=2'b11, data_ok in the cycle after entry with rdata=0x80FF_0000
//     -> final_result=0xFFFFFF80. Same with ld_bu -> 0x00000080.
//  3. ld_h, addr=2'b10, rdata=0x8001_7FFF, ws_allowin=0 when data_ok
//     -> state DONE, data_buf held.
//     -> ws_allowin=1 two cycles later -> result 0xFFFF8001, valid exactly one handoff.
//  4. Load in WAIT for 3 cycles -> ms_fwd_pending=1, ms_allowin=0 throughout.
//     -> data_ok pulse -> pending=0, valid=1 that cycle.
//  5. Back-to-back: st_w then ALU op, data_ok and es_to_ms_valid in the same cycle
//     -> store retires (gr_we=0), ALU op latched with no bubble.
//     -> stray data_ok in IDLE -> no output change.
//  6. resetn low while in WAIT -> immediately ms_to_ws_valid=0, ms_allowin=1.
//     -> data_ok after release -> ignored, stays IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between exe and writeback.
// Holds one instruction. Loads and stores wait here for the data-SRAM
// response (data_ok). Loads then pick out the addressed byte, half or word
// and extend it. The stage drives the writeback bus and gives decode a
// forwarding/stall view.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 82,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ms_fwd_we,
  output logic [4:0]                 ms_fwd_dest,
  output logic [31:0]                ms_fwd_data,
  output logic                       ms_fwd_pending
);

  localparam logic [1:0] IDLE = 2'd0;  // stage empty
  localparam logic [1:0] WAIT = 2'd1;  // memory op waiting for data_ok
  localparam logic [1:0] DONE = 2'd2;  // result ready, waiting for ws_allowin

  logic [1:0]                 state;
  logic [1:0]                 state_next;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
  logic [31:0]                data_buf;

  // Fields of the latched instruction
  logic [1:0]  ms_addr;
  logic        ms_mem_we;
  logic        ms_ld_w;
  logic        ms_ld_b;
  logic        ms_ld_bu;
  logic        ms_ld_h;
  logic        ms_ld_hu;
  logic        ms_st_w;
  logic        ms_st_b;
  logic        ms_st_h;
  logic        ms_res_from_mem;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_pc;

  assign {ms_addr, ms_mem_we, ms_ld_w, ms_ld_b, ms_ld_bu, ms_ld_h, ms_ld_hu,
          ms_st_w, ms_st_b, ms_st_h, ms_res_from_mem, ms_gr_we, ms_dest,
          ms_alu_result, ms_pc} = ms_bus_r;

  // The stage does not need the store width because the SRAM request is
  // issued upstream. Only the shared mem_we bit matters here.
  logic unused_store_kind;
  assign unused_store_kind = &{1'b0, ms_st_w, ms_st_b, ms_st_h};

  // need_rsp comes from the incoming bus. It decides where a newly accepted
  // instruction lands.
  logic in_need_rsp;
  assign in_need_rsp = es_to_ms_bus[79] | es_to_ms_bus[70];

  logic ms_valid;
  logic ms_ready_go;
  logic accept;
  logic handoff;
  logic ms_gr_we_eff;

  assign ms_valid       = (state != IDLE);
  assign ms_ready_go    = (state == DONE) | ((state == WAIT) & data_sram_data_ok);
  assign ms_allowin     = (state == IDLE) | (ms_ready_go & ws_allowin);
  assign accept         = es_to_ms_valid & ms_allowin;
  assign handoff        = ms_ready_go & ws_allowin;
  assign ms_gr_we_eff   = ms_gr_we & ~ms_mem_we;

  // Next-state selection: a new entry wins, then retirement, then buffering.
  always_comb begin
    // NOTE: default assignment first so that no path leaves state_next unassigned, which would infer a latch.
    state_next = state;
    if (accept) begin
      state_next = in_need_rsp ? WAIT : DONE;
    end else if (handoff) begin
      state_next = IDLE;
    end else if ((state == WAIT) && data_sram_data_ok) begin
      state_next = DONE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the exe payload on acceptance
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the payload and data registers are reset so that the output buses read zero after reset.
    if (!resetn) begin
      ms_bus_r <= '0;
    end else if (accept) begin
      ms_bus_r <= es_to_ms_bus;
    end
  end

  // Buffer read data only when it arrives while writeback is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_buf <= '0;
    end else if ((state == WAIT) && data_sram_data_ok && !ws_allowin) begin
      data_buf <= data_sram_rdata;
    end
  end

  // Load extraction: pick and extend the addressed byte, half or word
  logic [31:0] load_src;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] mem_result;

  always_comb begin
    load_src = (state == WAIT) ? data_sram_rdata : data_buf;
    case (ms_addr)
      2'd0:    byte_sel = load_src[7:0];
      2'd1:    byte_sel = load_src[15:8];
      2'd2:    byte_sel = load_src[23:16];
      default: byte_sel = load_src[31:24];
    endcase
    half_sel = ms_addr[1] ? load_src[31:16] : load_src[15:0];
    if (ms_ld_w) begin
      mem_result = load_src;
    end else if (ms_ld_b) begin
      mem_result = {{24{byte_sel[7]}}, byte_sel};
    end else if (ms_ld_bu) begin
      mem_result = {24'd0, byte_sel};
    end else if (ms_ld_h) begin
      mem_result = {{16{half_sel[15]}}, half_sel};
    end else if (ms_ld_hu) begin
      mem_result = {16'd0, half_sel};
    end else begin
      mem_result = load_src;
    end
  end

  logic [31:0] final_result;
  assign final_result = ms_res_from_mem ? mem_result : ms_alu_result;

  assign ms_to_ws_valid = ms_ready_go;
  assign ms_to_ws_bus   = {ms_gr_we_eff, ms_dest, final_result, ms_pc};

  assign ms_fwd_we      = ms_valid & ms_gr_we_eff;
  assign ms_fwd_dest    = ms_dest;
  assign ms_fwd_data    = final_result;
  assign ms_fwd_pending = (state == WAIT) & ms_res_from_mem & ~data_sram_data_ok;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic for mem_stage.
// The expected outputs come from an occupancy/data-arrival model of the
// stage. The bench compares them at each falling edge.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [81:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        ms_fwd_we;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_pending;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_dest       (ms_fwd_dest),
    .ms_fwd_data       (ms_fwd_data),
    .ms_fwd_pending    (ms_fwd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag groups, ordered {mem_we,ld_w,ld_b,ld_bu,ld_h,ld_hu,st_w,st_b,st_h,res_from_mem}
  localparam logic [9:0] F_ALU  = 10'b0000000000;
  localparam logic [9:0] F_LDW  = 10'b0100000001;
  localparam logic [9:0] F_LDB  = 10'b0010000001;
  localparam logic [9:0] F_LDBU = 10'b0001000001;
  localparam logic [9:0] F_LDH  = 10'b0000100001;
  localparam logic [9:0] F_LDHU = 10'b0000010001;
  localparam logic [9:0] F_STW  = 10'b1000001000;
  localparam logic [9:0] F_STB  = 10'b1000000100;
  localparam logic [9:0] F_STH  = 10'b1000000010;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [81:0] mk(input logic [1:0] addr, input logic [9:0] flags,
                                     input logic gr_we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {addr, flags, gr_we, dest, alu, pc};
  endfunction

  // Writeback value computed from the load rules using shifts and masks
  function automatic logic [31:0] ref_result(input logic [81:0] inst, input logic [31:0] src);
    int unsigned a;
    logic [31:0] b;
    logic [31:0] h;
    a = inst[81:80];
    b = (src >> (8 * a)) & 32'h0000_00ff;
    h = (src >> (16 * (a / 2))) & 32'h0000_ffff;
    if (!inst[70]) return inst[63:32];
    if (inst[78]) return src;
    if (inst[77]) return (b >= 32'd128) ? (b | 32'hffff_ff00) : b;
    if (inst[76]) return b;
    if (inst[75]) return (h >= 32'd32768) ? (h | 32'hffff_0000) : h;
    if (inst[74]) return h;
    return src;
  endfunction

  // Reference model: whether the stage holds an instruction, and whether its
  // memory data has already arrived
  bit          m_occ;
  bit          m_has;
  logic [31:0] m_data;
  logic [81:0] m_inst;

  // Values seen on the last falling edge, for the directed checks
  logic        obs_valid;
  logic        obs_allow;
  logic        obs_pend;
  logic [69:0] obs_bus;
  int          dut_handoffs = 0;

  task automatic model_reset();
    m_occ  = 1'b0;
    m_has  = 1'b0;
    m_data = '0;
    m_inst = '0;
  endtask

  // One clock: drive the inputs, compare with the model at the falling edge,
  // then advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [81:0] b, input logic wa,
                       input logic dok, input logic [31:0] rd);
    bit need;
    bit ready;
    bit allow;
    bit pend;
    logic [31:0] res;
    logic [69:0] exp_bus;
    es_to_ms_valid    = v;
    es_to_ms_bus      = b;
    ws_allowin        = wa;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    @(negedge clk);
    need    = m_inst[79] | m_inst[70];
    ready   = m_occ && (!need || m_has || dok);
    allow   = !m_occ || (ready && wa);
    pend    = m_occ && m_inst[70] && !m_has && !dok;
    res     = ref_result(m_inst, m_has ? m_data : rd);
    exp_bus = {m_inst[69] & ~m_inst[79], m_inst[68:64], res, m_inst[31:0]};
    check("valid", 70'(ms_to_ws_valid), 70'(ready));
    check("allowin", 70'(ms_allowin), 70'(allow));
    check("pending", 70'(ms_fwd_pending), 70'(pend));
    check("fwd_we", 70'(ms_fwd_we), 70'(m_occ && m_inst[69] && !m_inst[79]));
    if (m_occ) check("fwd_dest", 70'(ms_fwd_dest), 70'(m_inst[68:64]));
    if (ready) begin
      check("ws_bus", ms_to_ws_bus, exp_bus);
      check("fwd_data", 70'(ms_fwd_data), 70'(res));
    end
    obs_valid = ms_to_ws_valid;
    obs_allow = ms_allowin;
    obs_pend  = ms_fwd_pending;
    obs_bus   = ms_to_ws_bus;
    if (ms_to_ws_valid && wa) dut_handoffs++;
    @(posedge clk);
    if (ready && wa) begin
      m_occ = 1'b0;
    end else if (m_occ && need && !m_has && dok) begin
      m_has  = 1'b1;
      m_data = rd;
    end
    if (v && allow) begin
      m_occ  = 1'b1;
      m_has  = 1'b0;
      m_inst = b;
    end
    #1;
  endtask

  task automatic idle(input logic wa, input logic dok);
    cycle(1'b0, '0, wa, dok, $urandom);
  endtask

  int h0;
  logic [81:0] alu_op;

  initial begin
    resetn            = 1'b0;
    ws_allowin        = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    model_reset();
    #3;
    check("rst_valid", 70'(ms_to_ws_valid), 70'd0);
    check("rst_allowin", 70'(ms_allowin), 70'd1);
    check("rst_fwd_we", 70'(ms_fwd_we), 70'd0);
    check("rst_pending", 70'(ms_fwd_pending), 70'd0);
    check("rst_bus", ms_to_ws_bus, 70'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // 1. ALU op passes through in one cycle
    cycle(1'b1, mk(2'd0, F_ALU, 1'b1, 5'd5, 32'h1234, 32'h1c00_0000), 1'b1, 1'b0, 32'h0);
    idle(1'b1, 1'b0);
    check("t1_valid", 70'(obs_valid), 70'd1);
    check("t1_bus", obs_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000});
    check("t1_allowin", 70'(obs_allow), 70'd1);

    // 2. Signed and unsigned byte loads from the top byte
    cycle(1'b1, mk(2'd3, F_LDB, 1'b1, 5'd7, 32'h0, 32'h1c00_0004), 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h80ff_0000);
    check("t2_ldb", 70'(obs_bus[63:32]), 70'(32'hffff_ff80));
    cycle(1'b1, mk(2'd3, F_LDBU, 1'b1, 5'd7, 32'h0, 32'h1c00_0008), 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h80ff_0000);
    check("t2_ldbu", 70'(obs_bus[63:32]), 70'(32'h0000_0080));

    // 3. Half load whose data arrives while writeback is stalled
    h0 = dut_handoffs;
    cycle(1'b1, mk(2'd2, F_LDH, 1'b1, 5'd9, 32'h0, 32'h1c00_000c), 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h8001_7fff);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b1);
    check("t3_result", 70'(obs_bus[63:32]), 70'(32'hffff_8001));
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check("t3_handoffs", 70'(dut_handoffs - h0), 70'd1);

    // 4. Load stalled in WAIT exposes pending to decode
    cycle(1'b1, mk(2'd0, F_LDW, 1'b1, 5'd3, 32'h0, 32'h1c00_0010), 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(2'd0, F_ALU, 1'b1, 5'd4, 32'h55, 32'h1c00_0014), 1'b1, 1'b0, 32'h0);
      check("t4_pending", 70'(obs_pend), 70'd1);
      check("t4_allowin", 70'(obs_allow), 70'd0);
    end
    cycle(1'b0, '0, 1'b1, 1'b1, 32'hdead_beef);
    check("t4_pend_drop", 70'(obs_pend), 70'd0);
    check("t4_valid", 70'(obs_valid), 70'd1);

    // 5. Store retires while the next ALU op enters, then a stray data_ok arrives
    alu_op = mk(2'd0, F_ALU, 1'b1, 5'd12, 32'hcafe_0001, 32'h1c00_0020);
    cycle(1'b1, mk(2'd1, F_STW, 1'b1, 5'd11, 32'h1000, 32'h1c00_001c), 1'b1, 1'b0, 32'h0);
    cycle(1'b1, alu_op, 1'b1, 1'b1, 32'h1111_2222);
    check("t5_st_valid", 70'(obs_valid), 70'd1);
    check("t5_st_grwe", 70'(obs_bus[69]), 70'd0);
    idle(1'b1, 1'b0);
    check("t5_alu_valid", 70'(obs_valid), 70'd1);
    check("t5_alu_bus", obs_bus, {1'b1, 5'd12, 32'hcafe_0001, 32'h1c00_0020});
    idle(1'b1, 1'b1);
    check("t5_stray_valid", 70'(obs_valid), 70'd0);
    check("t5_stray_bus", obs_bus, {1'b1, 5'd12, 32'hcafe_0001, 32'h1c00_0020});

    // 6. Reset asserted mid-WAIT drops the load
    cycle(1'b1, mk(2'd0, F_LDW, 1'b1, 5'd6, 32'h0, 32'h1c00_0024), 1'b1, 1'b0, 32'h0);
    es_to_ms_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("t6_valid", 70'(ms_to_ws_valid), 70'd0);
    check("t6_allowin", 70'(ms_allowin), 70'd1);
    check("t6_pending", 70'(ms_fwd_pending), 70'd0);
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(1'b1, 1'b1);
    check("t6_stray", 70'(obs_valid), 70'd0);
    idle(1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [9:0] fl;
      logic       gw;
      int         k;
      k = $urandom_range(0, 8);
      case (k)
        0: fl = F_ALU;
        1: fl = F_LDW;
        2: fl = F_LDB;
        3: fl = F_LDBU;
        4: fl = F_LDH;
        5: fl = F_LDHU;
        6: fl = F_STW;
        7: fl = F_STB;
        default: fl = F_STH;
      endcase
      gw = fl[0] ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)),
            mk(2'($urandom_range(0, 3)), fl, gw, 5'($urandom_range(0, 31)), $urandom, $urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
